// File: rtl/alu_req_sched_pkg.sv
// Shared types and constants for the two-requester ALU scheduler.
// Opcode map, ALU select codes, FSM states and the opcode decoder.
package alu_req_sched_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned SHAMT_W    = 4;
    localparam int unsigned SEL_W      = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_SLA  = 4'd6,
        OP_SRA  = 4'd7,
        OP_ADDC = 4'd8,
        OP_SUBC = 4'd9
    } op_e;

    localparam logic [SEL_W-1:0] SEL_ADDSUB = 3'd0;
    localparam logic [SEL_W-1:0] SEL_AND    = 3'd1;
    localparam logic [SEL_W-1:0] SEL_OR     = 3'd2;
    localparam logic [SEL_W-1:0] SEL_SLL    = 3'd3;
    localparam logic [SEL_W-1:0] SEL_SRL    = 3'd4;
    localparam logic [SEL_W-1:0] SEL_SLA    = 3'd5;
    localparam logic [SEL_W-1:0] SEL_SRA    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Decoded control for one request; cin is cin_one | (cin_flag & carry flag)
    typedef struct packed {
        logic             legal;
        logic             arith;
        logic [SEL_W-1:0] sel;
        logic             opz;
        logic             cin_one;
        logic             cin_flag;
    } dec_t;

    function automatic dec_t op_decode(input logic [OP_W-1:0] op, input logic carry_en);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_ADD:  begin d.arith = 1'b1; d.sel = SEL_ADDSUB; end
            OP_SUB:  begin d.arith = 1'b1; d.sel = SEL_ADDSUB; d.opz = 1'b1; d.cin_one = 1'b1; end
            OP_AND:  d.sel = SEL_AND;
            OP_OR:   d.sel = SEL_OR;
            OP_SLL:  d.sel = SEL_SLL;
            OP_SRL:  d.sel = SEL_SRL;
            OP_SLA:  d.sel = SEL_SLA;
            OP_SRA:  d.sel = SEL_SRA;
            OP_ADDC: begin d.legal = carry_en; d.arith = 1'b1; d.cin_flag = 1'b1; end
            OP_SUBC: begin d.legal = carry_en; d.arith = 1'b1; d.opz = 1'b1; d.cin_flag = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_req_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester
// and moves to the side opposite the winner on every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] grant_c
);

    logic ptr_q;

    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (upd && (grant_c != 2'b00)) begin
            ptr_q <= grant_c[0];
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Scheduler/sequencer in front of the shared ALU: arbitrates two requesters,
// drives the ALU for one cycle and returns the registered result.
// Optional feature macro: ALU_REQ_SCHED_CARRY_EN (per-requester carry flags, ADDC/SUBC).
module alu_req_sched
    import alu_req_sched_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*OP_W-1:0]     req_op,
    input  logic [2*DATA_W-1:0]   req_a,
    input  logic [2*DATA_W-1:0]   req_b,
    input  logic [2*SHAMT_W-1:0]  req_shamt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_cout,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     alu_i1,
    output logic [DATA_W-1:0]     alu_i2,
    output logic [SEL_W-1:0]      alu_sel,
    output logic                  alu_opz,
    output logic                  alu_cin,
    output logic [SHAMT_W-1:0]    alu_shamt,
    input  logic [DATA_W-1:0]     alu_o,
    input  logic                  alu_cout
);

`ifdef ALU_REQ_SCHED_CARRY_EN
    localparam logic CARRY_EN = 1'b1;
`else
    localparam logic CARRY_EN = 1'b0;
`endif

    state_e               state_q;
    state_e               state_d;
    logic [1:0]           grant_c;
    logic                 hs_c;
    logic                 sel_id_c;
    logic [OP_W-1:0]      sel_op_c;
    logic [DATA_W-1:0]    sel_a_c;
    logic [DATA_W-1:0]    sel_b_c;
    logic [SHAMT_W-1:0]   sel_shamt_c;
    dec_t                 dec_c;
    logic                 flag_c;
    logic                 ld_exec_c;
    logic                 ld_err_c;
    logic                 cap_c;
    logic                 rsp_done_c;
    logic                 id_q;
    logic                 arith_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .upd     (hs_c),
        .grant_c (grant_c)
    );

    // Payload of the granted requester; only sampled on the handshake cycle
    always_comb begin
        sel_id_c    = grant_c[1];
        sel_op_c    = sel_id_c ? req_op[2*OP_W-1:OP_W]         : req_op[OP_W-1:0];
        sel_a_c     = sel_id_c ? req_a[2*DATA_W-1:DATA_W]      : req_a[DATA_W-1:0];
        sel_b_c     = sel_id_c ? req_b[2*DATA_W-1:DATA_W]      : req_b[DATA_W-1:0];
        sel_shamt_c = sel_id_c ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
    end

    // Ready is gated by rst_n so it reads 0 while reset is held
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == ST_IDLE) && rst_n) begin
            req_ready = grant_c;
        end
        hs_c = (req_ready != 2'b00);
    end

    assign dec_c = op_decode(sel_op_c, CARRY_EN);

`ifdef ALU_REQ_SCHED_CARRY_EN
    logic [1:0] carry_q;

    assign flag_c = carry_q[sel_id_c];

    // Only arithmetic ops that reached the ALU touch their owner's flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 2'b00;
        end else if (cap_c && arith_q) begin
            carry_q[id_q] <= alu_cout;
        end
    end
`else
    assign flag_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ld_exec_c  = 1'b0;
        ld_err_c   = 1'b0;
        cap_c      = 1'b0;
        rsp_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_c) begin
                    ld_exec_c = dec_c.legal;
                    ld_err_c  = !dec_c.legal;
                    state_d   = dec_c.legal ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                cap_c   = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done_c = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU controls are loaded on the handshake so they are valid exactly in EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q      <= 1'b0;
            arith_q   <= 1'b0;
            alu_i1    <= '0;
            alu_i2    <= '0;
            alu_sel   <= '0;
            alu_opz   <= 1'b0;
            alu_cin   <= 1'b0;
            alu_shamt <= '0;
        end else begin
            if (hs_c) begin
                id_q    <= sel_id_c;
                arith_q <= dec_c.arith;
            end
            if (ld_exec_c) begin
                alu_i1    <= sel_a_c;
                alu_i2    <= sel_b_c;
                alu_sel   <= dec_c.sel;
                alu_opz   <= dec_c.opz;
                alu_cin   <= dec_c.cin_one | (dec_c.cin_flag & flag_c);
                alu_shamt <= sel_shamt_c;
            end else if (cap_c) begin
                alu_i1    <= '0;
                alu_i2    <= '0;
                alu_sel   <= '0;
                alu_opz   <= 1'b0;
                alu_cin   <= 1'b0;
                alu_shamt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (ld_err_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= sel_id_c;
            rsp_data  <= '0;
            rsp_cout  <= 1'b0;
            rsp_err   <= 1'b1;
        end else if (cap_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= alu_o;
            rsp_cout  <= arith_q & alu_cout;
            rsp_err   <= 1'b0;
        end else if (rsp_done_c) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed bench for alu_req_sched with a behavioural model of the shared ALU.
// Expected values follow ALU_REQ_SCHED_CARRY_EN when defined.
module tb_alu_req_sched;

    localparam int unsigned DW = 16;

`ifdef ALU_REQ_SCHED_CARRY_EN
    localparam logic CE = 1'b1;
`else
    localparam logic CE = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [7:0]    req_op;
    logic [2*DW-1:0] req_a;
    logic [2*DW-1:0] req_b;
    logic [7:0]    req_shamt;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [DW-1:0] rsp_data;
    logic          rsp_cout;
    logic          rsp_err;
    logic [DW-1:0] alu_i1;
    logic [DW-1:0] alu_i2;
    logic [2:0]    alu_sel;
    logic          alu_opz;
    logic          alu_cin;
    logic [3:0]    alu_shamt;
    logic [DW-1:0] alu_o;
    logic          alu_cout;

    int n_checks = 0;
    int n_err    = 0;

    alu_req_sched #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .alu_i1    (alu_i1),
        .alu_i2    (alu_i2),
        .alu_sel   (alu_sel),
        .alu_opz   (alu_opz),
        .alu_cin   (alu_cin),
        .alu_shamt (alu_shamt),
        .alu_o     (alu_o),
        .alu_cout  (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden ALU: combinational, as the real datapath
    logic [DW-1:0] alu_b_eff;
    logic [DW:0]   alu_sum;
    always_comb begin
        alu_b_eff = alu_opz ? ~alu_i2 : alu_i2;
        alu_sum   = {1'b0, alu_i1} + {1'b0, alu_b_eff} + {{DW{1'b0}}, alu_cin};
        case (alu_sel)
            3'd0:    alu_o = alu_sum[DW-1:0];
            3'd1:    alu_o = alu_i1 & alu_i2;
            3'd2:    alu_o = alu_i1 | alu_i2;
            3'd3:    alu_o = alu_i1 << alu_shamt;
            3'd4:    alu_o = alu_i1 >> alu_shamt;
            3'd5:    alu_o = alu_i1 <<< alu_shamt;
            3'd6:    alu_o = DW'($signed(alu_i1) >>> alu_shamt);
            default: alu_o = '0;
        endcase
        alu_cout = (alu_sel == 3'd0) ? alu_sum[DW] : 1'b0;
    end

    typedef struct {
        logic          id;
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [3:0]    sh;
        logic [2:0]    sel;
        logic          opz;
        logic          cin;
        logic [DW-1:0] data;
        logic          cout;
        logic          err;
    } vec_t;

    function automatic vec_t mk(input logic id, input logic [3:0] op, input logic [DW-1:0] a,
                                input logic [DW-1:0] b, input logic [3:0] sh, input logic [2:0] sel,
                                input logic opz, input logic cin, input logic [DW-1:0] data,
                                input logic cout, input logic err);
        vec_t v;
        v.id = id; v.op = op; v.a = a; v.b = b; v.sh = sh; v.sel = sel;
        v.opz = opz; v.cin = cin; v.data = data; v.cout = cout; v.err = err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] alu_outs();
        return 64'({alu_i1, alu_i2, alu_sel, alu_opz, alu_cin, alu_shamt});
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({req_ready, rsp_valid, rsp_id, rsp_data, rsp_cout, rsp_err,
                    alu_i1, alu_i2, alu_sel, alu_opz, alu_cin, alu_shamt});
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic id, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [3:0] sh);
        if (id) begin
            req_op[7:4] = op; req_a[2*DW-1:DW] = a; req_b[2*DW-1:DW] = b; req_shamt[7:4] = sh;
        end else begin
            req_op[3:0] = op; req_a[DW-1:0] = a; req_b[DW-1:0] = b; req_shamt[3:0] = sh;
        end
    endtask

    // One request from handshake to consumed response, rsp_ready held at 1
    task automatic run_vec(input vec_t v);
        drive(v.id, v.op, v.a, v.b, v.sh);
        req_valid = v.id ? 2'b10 : 2'b01;
        #1;
        check("ready", 64'(req_ready), 64'(req_valid));
        tick();
        req_valid = 2'b00;
        req_a = ~req_a; req_b = ~req_b; req_shamt = ~req_shamt;
        #1;
        if (v.err) begin
            check("err_alu_idle", alu_outs(), 64'd0);
            check("err_rsp", 64'({rsp_valid, rsp_err, rsp_data, rsp_cout, rsp_id}),
                  64'({1'b1, 1'b1, 16'h0000, 1'b0, v.id}));
        end else begin
            check("exec_alu", alu_outs(), 64'({v.a, v.b, v.sel, v.opz, v.cin, v.sh}));
            check("exec_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
            check("rsp", 64'({rsp_valid, rsp_err, rsp_data, rsp_cout, rsp_id}),
                  64'({1'b1, 1'b0, v.data, v.cout, v.id}));
            check("rsp_alu_idle", alu_outs(), 64'd0);
        end
        tick();
        check("rsp_cleared", 64'(rsp_valid), 64'd0);
    endtask

    vec_t vecs[14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int nrsp;
        int last;
        logic [1:0] exp_g;

        vecs[0]  = mk(1'b0, 4'd0, 16'h0003, 16'h0004, 4'd0, 3'd0, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 4'd0, 16'hFFFF, 16'h0001, 4'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[2]  = CE ? mk(1'b1, 4'd8, 16'h0000, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0)
                      : mk(1'b1, 4'd8, 16'h0000, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        vecs[3]  = CE ? mk(1'b0, 4'd8, 16'h0000, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0)
                      : mk(1'b0, 4'd8, 16'h0000, 16'h0000, 4'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        vecs[4]  = mk(1'b0, 4'd1, 16'h0005, 16'h0003, 4'd0, 3'd0, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 4'd2, 16'hF0F0, 16'h0FF0, 4'd0, 3'd1, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 4'd3, 16'h1200, 16'h0034, 4'd0, 3'd2, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 4'd4, 16'h0001, 16'h0000, 4'd4, 3'd3, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
        vecs[8]  = mk(1'b1, 4'd5, 16'h8000, 16'h0000, 4'd4, 3'd4, 1'b0, 1'b0, 16'h0800, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 4'd7, 16'h8000, 16'h0000, 4'd4, 3'd6, 1'b0, 1'b0, 16'hF800, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 4'd6, 16'h0003, 16'h0000, 4'd2, 3'd5, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0);
        vecs[11] = CE ? mk(1'b0, 4'd9, 16'h0001, 16'h0001, 4'd0, 3'd0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0)
                      : mk(1'b0, 4'd9, 16'h0001, 16'h0001, 4'd0, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        vecs[12] = mk(1'b1, 4'hC, 16'h1234, 16'h5678, 4'd3, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        vecs[13] = mk(1'b0, 4'hF, 16'hAAAA, 16'h5555, 4'd1, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        rst_n = 1'b0; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0;
        req_shamt = '0; rsp_ready = 1'b1;
        #3;
        check("reset_outs", all_outs(), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        check("post_reset_outs", all_outs(), 64'd0);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Illegal opcode held in RESP while the other requester waits
        rsp_ready = 1'b0;
        drive(1'b0, 4'hC, 16'h1111, 16'h2222, 4'd0);
        req_valid = 2'b01;
        #1;
        check("ill_ready", 64'(req_ready), 64'(2'b01));
        tick();
        drive(1'b1, 4'd0, 16'h0010, 16'h0020, 4'd0);
        req_valid = 2'b10;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("ill_hold", 64'({req_ready, rsp_valid, rsp_err, rsp_data, rsp_cout, rsp_id}),
                  64'({2'b00, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0}));
            check("ill_alu_idle", alu_outs(), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("post_rsp_grant", 64'({req_ready, rsp_valid}), 64'({2'b10, 1'b0}));
        tick();
        req_valid = 2'b00;
        tick();
        check("post_rsp_data", 64'({rsp_valid, rsp_id, rsp_data}), 64'({1'b1, 1'b1, 16'h0030}));
        tick();

        // Reset asserted during EXEC drops the request
        drive(1'b0, 4'd0, 16'h1111, 16'h2222, 4'd0);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        #1;
        check("exec_before_rst", 64'({alu_i1, alu_i2, alu_sel}), 64'({16'h1111, 16'h2222, 3'd0}));
        rst_n = 1'b0;
        #1;
        check("rst_mid_exec", all_outs(), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("no_replay", 64'({rsp_valid, alu_sel, alu_i1}), 64'd0);
        end

        // Both requesters valid: alternating grants every 3 cycles from pointer 0
        drive(1'b0, 4'd0, 16'h0001, 16'h0001, 4'd0);
        drive(1'b1, 4'd0, 16'h0002, 16'h0002, 4'd0);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        got = 0; nrsp = 0; last = 0;
        #1;
        for (int cyc = 0; cyc < 30 && (got < 4 || nrsp < 4); cyc++) begin
            if (req_ready != 2'b00 && got < 4) begin
                exp_g = got[0] ? 2'b10 : 2'b01;
                check("bv_grant", 64'(req_ready), 64'(exp_g));
                if (got > 0) check("bv_spacing", 64'(cyc - last), 64'd3);
                last = cyc;
                got++;
            end
            if (rsp_valid) begin
                check("bv_rsp", 64'({rsp_id, rsp_data}),
                      64'({nrsp[0], (nrsp[0] ? 16'h0004 : 16'h0002)}));
                nrsp++;
            end
            tick();
            if (got == 4) req_valid = 2'b00;
            #1;
        end
        check("bv_done", 64'(got * 10 + nrsp), 64'd44);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_req_sched.md
# alu_req_sched

Two-requester scheduler and sequencer for the shared 16-bit ALU datapath (add/sub, AND, OR, logical/arithmetic shifts). It accepts operation requests over valid/ready, arbitrates round-robin, drives the ALU's select, carry and shift-amount controls, registers the combinational result, and returns it on a valid/ready response channel tagged with the requester ID. Per-requester carry flags support multi-word add/subtract chains.

## Interface
- `DATA_W`, default 16: operand/result width; must match the ALU.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: request valid, one bit per requester.
- `req_ready` out 2: request accepted; at most one bit high.
- `req_op` in 2x4: opcode per requester.
- `req_a`, `req_b` in 2xDATA_W: operands per requester.
- `req_shamt` in 2x4: shift amount per requester.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumed.
- `rsp_id` out 1: requester index of the response.
- `rsp_data` out DATA_W: registered ALU result.
- `rsp_cout` out 1: ALU carry-out for add/sub ops, else 0.
- `rsp_err` out 1: illegal opcode.
- `alu_i1`, `alu_i2` out DATA_W: ALU operands.
- `alu_sel` out 3: result select. 0 add/sub, 1 AND, 2 OR, 3 SLL, 4 SRL, 5 SLA, 6 SRA.
- `alu_opz` out 1: 1 = subtract.
- `alu_cin` out 1: ALU carry-in.
- `alu_shamt` out 4: shift amount.
- `alu_o` in DATA_W: ALU result.
- `alu_cout` in 1: ALU carry-out.

## Operation
- Opcodes:
  - 0 ADD: `opz`=0, `cin`=0.
  - 1 SUB: `opz`=1, `cin`=1.
  - 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SLA, 7 SRA.
  - 8 ADDC: `cin` = carry flag.
  - 9 SUBC: `opz`=1, `cin` = carry flag.
  - 10–15 are illegal.
- FSM states:
  - IDLE: grant computed from `req_valid` and the round-robin pointer. `req_ready[g]` = grant. On handshake, latch op, operands, shamt and ID, then go to EXEC.
  - EXEC: drive the `alu_*` outputs from the latched request for exactly one cycle. At the cycle's end, capture `alu_o`/`alu_cout` into the response registers, set `rsp_valid`, go to RESP.
  - RESP: hold all `rsp_*` stable until `rsp_ready`=1, then clear `rsp_valid` and return to IDLE.
- Arbitration:
  - Pointer names the preferred requester; it resets to 0.
  - Both requesters valid: the pointer side wins, and the pointer moves to the other side after the grant.
  - One requester valid: it wins, and the pointer moves past it.
- Carry flags, one per requester:
  - Updated with `alu_cout` on ops 0, 1, 8, 9 by the owning requester only.
  - Unchanged by logic/shift ops and by errors.
- Illegal opcode: skip EXEC; go straight to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_cout`=0. The ALU stays undriven and flags are unchanged.
- `rsp_cout` = 0 for logic and shift ops.
- Outside EXEC, all `alu_*` outputs are 0.
- `req_ready` is 0 outside IDLE. A requester may hold `req_valid` with changing payload until accepted; only the handshake cycle is sampled.

## Timing
- Request handshake in cycle N → ALU driven in N+1 → `rsp_valid`=1 in N+2.
- Minimum spacing is one accepted request per 3 cycles when `rsp_ready` is held at 1.
- A new request can be accepted in the cycle after the `rsp_ready` handshake.
- `alu_o` is a combinational path through the ALU within the EXEC cycle; no ALU pipelining.
- Reset values:
  - State IDLE, pointer 0, carry flags 0.
  - `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_cout`, `rsp_err` all 0.
  - All `alu_*` outputs 0; `req_ready` 0.
- Reset asserted mid-EXEC or mid-RESP: the in-flight request and response are dropped and not replayed.

## Configuration
- `ALU_REQ_SCHED_CARRY_EN` defined: carry flags are implemented and opcodes 8/9 are legal.
- Undefined: no flag registers; opcodes 8/9 are illegal (`rsp_err`=1). All other behaviour is identical.

## Structure
- Package `alu_req_sched_pkg` holds:
  - opcode enum;
  - `alu_sel` constants;
  - FSM state enum;
  - `DATA_W` default.
- Sub-module `rr_arb2`: 2-way round-robin arbiter. Inputs: requests, pointer-update enable. Outputs: one-hot grant. Holds the pointer flop.

## Test plan
- Reset, then requester 0 sends ADD a=0x0003, b=0x0004 → `req_ready[0]` in N; `alu_sel`=0, `cin`=0 in N+1; N+2 gives `rsp_data`=0x0007, `rsp_cout`=0, `rsp_id`=0.
- Both requesters valid every cycle, `rsp_ready`=1 → grants alternate 0,1,0,1; responses arrive every 3 cycles.
- Requester 1: ADD 0xFFFF+0x0001, then ADDC 0x0000+0x0000 → `rsp_data`=0x0000 with `cout`=1, then `rsp_data`=0x0001. Requester 0's flag stays 0.
- SRA a=0x8000, shamt=4 → `alu_sel`=6, `alu_shamt`=4; `rsp_data` equals the ALU output (0xF800 with the golden ALU model).
- Opcode 0xC → `rsp_err`=1, `rsp_data`=0, `alu_*` stay 0, `rsp_valid` in N+1. Hold `rsp_ready`=0 for 5 cycles → response stable and `req_ready`=0 throughout.
- Assert `rst_n`=0 during EXEC → all outputs 0 immediately. After release, a new ADD completes normally.
